// File: rtl/cbf_block_updater.sv
// cbf_block_updater: unpipelined read-modify-write engine for one counting-Bloom-filter block.
//
// A command (query/insert/delete) carries a block address and NUM_HASHES packed hashes. The
// engine reads the block, then registers the updated block and a response. The response
// reports whether every hashed entry was nonzero and the smallest hashed entry. The
// response reflects the block as read, before any update. Insert and delete then write the
// block back. Only one command is in flight, so a read never sees a stale block.
//
// Ports:
//   clk, rstb                   clock, asynchronous active-low reset
//   cmdValid/cmdReady           command handshake
//   cmdOp                       00 query, 01 insert, 10 delete, 11 query
//   cmdBlockAddr, cmdHashes     block address; hash l at [(l+1)*N-1:l*N]
//   memReadEn/Addr/Data         block read; data valid one cycle after memReadEn
//   memWriteEn/Addr/Data        block write-back
//   respValid/respReady         response handshake
//   respPresent, respMinCount   pre-update membership and minimum count
module cbf_block_updater #(
  parameter int unsigned NUM_HASHES                 = 6,
  parameter int unsigned VECTOR_WIDTH               = 1024,
  parameter int unsigned NUM_BITS_TO_ADDRESS_VECTOR = 10,
  parameter int unsigned CBF_WIDTH                  = 4,
  parameter int unsigned ADDR_WIDTH                 = 12
) (
  input  logic                                             clk,
  input  logic                                             rstb,
  input  logic                                             cmdValid,
  output logic                                             cmdReady,
  input  logic [1:0]                                       cmdOp,
  input  logic [ADDR_WIDTH-1:0]                            cmdBlockAddr,
  input  logic [NUM_BITS_TO_ADDRESS_VECTOR*NUM_HASHES-1:0] cmdHashes,
  output logic                                             memReadEn,
  output logic [ADDR_WIDTH-1:0]                            memReadAddr,
  input  logic [CBF_WIDTH*VECTOR_WIDTH-1:0]                memReadData,
  output logic                                             memWriteEn,
  output logic [ADDR_WIDTH-1:0]                            memWriteAddr,
  output logic [CBF_WIDTH*VECTOR_WIDTH-1:0]                memWriteData,
  output logic                                             respValid,
  input  logic                                             respReady,
  output logic                                             respPresent,
  output logic [CBF_WIDTH-1:0]                             respMinCount
);

  localparam int unsigned N  = NUM_BITS_TO_ADDRESS_VECTOR;
  localparam int unsigned HW = N * NUM_HASHES;
  localparam int unsigned BW = CBF_WIDTH * VECTOR_WIDTH;

  localparam logic [1:0]           OpInsert = 2'b01;
  localparam logic [1:0]           OpDelete = 2'b10;
  localparam logic [CBF_WIDTH-1:0] EntryMax = '1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StHold} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [HW-1:0]          hashes_q;
  logic [BW-1:0]          block_q, block_d;
  logic                   present_q, present_d;
  logic [CBF_WIDTH-1:0]   min_q, min_d;
  logic [VECTOR_WIDTH-1:0] hit;

  // Hit mask. Duplicate hashes collapse to a single hit.
  // Out-of-range hashes match no entry.
  always_comb begin
    hit = '0;
    for (int unsigned m = 0; m < VECTOR_WIDTH; m++) begin
      for (int unsigned l = 0; l < NUM_HASHES; l++) begin
        if (32'(hashes_q[l*N +: N]) == m) hit[m] = 1'b1;
      end
    end
  end

  // Pre-update response. An out-of-range hash reads as a zero entry.
  always_comb begin
    int unsigned          idx;
    logic [CBF_WIDTH-1:0] val;
    idx       = 0;
    val       = '0;
    present_d = 1'b1;
    min_d     = EntryMax;
    for (int unsigned l = 0; l < NUM_HASHES; l++) begin
      idx = 32'(hashes_q[l*N +: N]);
      val = '0;
      if (idx < VECTOR_WIDTH) val = memReadData[idx*CBF_WIDTH +: CBF_WIDTH];
      if (val == '0) present_d = 1'b0;
      if (val < min_d) min_d = val;
    end
  end

  // Saturating update. An all-ones entry is sticky under delete, because it may have
  // overflowed. With CBF_WIDTH == 1, a delete therefore never changes a bit.
  always_comb begin
    logic [CBF_WIDTH-1:0] e;
    e       = '0;
    block_d = memReadData;
    for (int unsigned m = 0; m < VECTOR_WIDTH; m++) begin
      e = memReadData[m*CBF_WIDTH +: CBF_WIDTH];
      if (hit[m]) begin
        if (op_q == OpInsert && e != EntryMax) begin
          block_d[m*CBF_WIDTH +: CBF_WIDTH] = e + 1'b1;
        end else if (op_q == OpDelete && e != '0 && e != EntryMax) begin
          block_d[m*CBF_WIDTH +: CBF_WIDTH] = e - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmdValid) state_d = StRead;
      StRead:  state_d = StWrite;
      StWrite: state_d = respReady ? StIdle : StHold;
      StHold:  if (respReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= StIdle;
      op_q      <= '0;
      addr_q    <= '0;
      hashes_q  <= '0;
      block_q   <= '0;
      present_q <= 1'b0;
      min_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && cmdValid) begin
        op_q     <= cmdOp;
        addr_q   <= cmdBlockAddr;
        hashes_q <= cmdHashes;
      end
      if (state_q == StRead) begin
        block_q   <= block_d;
        present_q <= present_d;
        min_q     <= min_d;
      end
    end
  end

  always_comb begin
    cmdReady     = (state_q == StIdle);
    memReadEn    = (state_q == StIdle) && cmdValid;
    memReadAddr  = memReadEn ? cmdBlockAddr : '0;
    memWriteEn   = (state_q == StWrite) && (op_q == OpInsert || op_q == OpDelete);
    memWriteAddr = addr_q;
    memWriteData = block_q;
    respValid    = (state_q == StWrite) || (state_q == StHold);
    respPresent  = present_q;
    respMinCount = min_q;
  end

endmodule

// File: tb/tb_cbf_block_updater.sv
// Self-checking bench for cbf_block_updater: 16 entries x 4 bits, 3 hashes of 4 bits.
// Command vectors come from a table that holds hand-derived response values. Expected
// write-backs come from a shadow memory model. Both are queued when a command is driven,
// and a negedge monitor pops and compares them when the DUT responds.
module tb_cbf_block_updater;

  localparam int unsigned NH = 3;
  localparam int unsigned VW = 16;
  localparam int unsigned NB = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 12;

  logic                 clk, rstb;
  logic                 cmdValid, cmdReady;
  logic [1:0]           cmdOp;
  logic [AW-1:0]        cmdBlockAddr;
  logic [NB*NH-1:0]     cmdHashes;
  logic                 memReadEn;
  logic [AW-1:0]        memReadAddr;
  logic [CW*VW-1:0]     memReadData;
  logic                 memWriteEn;
  logic [AW-1:0]        memWriteAddr;
  logic [CW*VW-1:0]     memWriteData;
  logic                 respValid, respReady, respPresent;
  logic [CW-1:0]        respMinCount;

  cbf_block_updater #(
    .NUM_HASHES                 (NH),
    .VECTOR_WIDTH               (VW),
    .NUM_BITS_TO_ADDRESS_VECTOR (NB),
    .CBF_WIDTH                  (CW),
    .ADDR_WIDTH                 (AW)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .cmdValid     (cmdValid),
    .cmdReady     (cmdReady),
    .cmdOp        (cmdOp),
    .cmdBlockAddr (cmdBlockAddr),
    .cmdHashes    (cmdHashes),
    .memReadEn    (memReadEn),
    .memReadAddr  (memReadAddr),
    .memReadData  (memReadData),
    .memWriteEn   (memWriteEn),
    .memWriteAddr (memWriteAddr),
    .memWriteData (memWriteData),
    .respValid    (respValid),
    .respReady    (respReady),
    .respPresent  (respPresent),
    .respMinCount (respMinCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory with one-cycle read latency, plus a backdoor preload port.
  logic [63:0]   mem     [0:4095] = '{default: '0};
  logic [63:0]   ref_mem [0:4095] = '{default: '0};
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [63:0]   pre_data = '0;

  always @(posedge clk) begin
    if (memReadEn) memReadData <= mem[memReadAddr];
    if (memWriteEn) mem[memWriteAddr] <= memWriteData;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [3:0]    h0, h1, h2;
    int            hold;
    logic          exp_p;
    logic [3:0]    exp_m;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic          p;
    logic [3:0]    m;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   writes_seen = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] model(input logic [63:0] blk, input logic [1:0] op,
                                        input logic [11:0] hs);
    logic [63:0] nb;
    logic [3:0]  e;
    logic        hit;
    nb = blk;
    for (int m = 0; m < 16; m++) begin
      hit = 1'b0;
      for (int l = 0; l < 3; l++) if (hs[l*4 +: 4] == 4'(m)) hit = 1'b1;
      e = blk[m*4 +: 4];
      if (hit && op == 2'b01 && e != 4'hF) nb[m*4 +: 4] = e + 4'd1;
      if (hit && op == 2'b10 && e != 4'h0 && e != 4'hF) nb[m*4 +: 4] = e - 4'd1;
    end
    return nb;
  endfunction

  // Scoreboard monitor: write-backs and accepted responses against the queue head.
  always @(negedge clk) begin
    if (rstb) begin
      if (memWriteEn) begin
        if (sb.size() == 0) begin
          check("spurious_write", 1'b1, 1'b0);
        end else begin
          check("write_addr", memWriteAddr, sb[0].addr);
          check("write_data", memWriteData, sb[0].data);
          writes_seen++;
        end
      end
      if (respValid && respReady) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 1'b1, 1'b0);
        end else begin
          check("resp_present", respPresent, sb[0].p);
          check("resp_min", respMinCount, sb[0].m);
          check("write_count", writes_seen, sb[0].we ? 1 : 0);
          writes_seen = 0;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic run_cmd(input vec_t v);
    exp_t        e;
    logic        p0;
    logic [3:0]  m0;
    logic        done;
    @(posedge clk); #1;
    cmdValid     = 1'b1;
    cmdOp        = v.op;
    cmdBlockAddr = v.addr;
    cmdHashes    = {v.h2, v.h1, v.h0};
    respReady    = (v.hold == 0);
    #1;
    check("idle_cmd_ready", cmdReady, 1'b1);
    check("read_en", memReadEn, 1'b1);
    check("read_addr", memReadAddr, v.addr);
    e.we   = (v.op == 2'b01) || (v.op == 2'b10);
    e.addr = v.addr;
    e.data = model(ref_mem[v.addr], v.op, {v.h2, v.h1, v.h0});
    e.p    = v.exp_p;
    e.m    = v.exp_m;
    sb.push_back(e);
    if (e.we) ref_mem[v.addr] = e.data;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    @(negedge clk);
    check("read_resp_valid", respValid, 1'b0);
    check("read_cmd_ready", cmdReady, 1'b0);
    if (v.hold > 0) begin
      @(posedge clk); #1;
      // A command offered while busy must not be consumed.
      cmdValid     = 1'b1;
      cmdOp        = 2'b01;
      cmdBlockAddr = 12'h077;
      p0 = 1'b0;
      m0 = '0;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        check("hold_resp_valid", respValid, 1'b1);
        check("hold_cmd_ready", cmdReady, 1'b0);
        check("hold_read_en", memReadEn, 1'b0);
        if (i == 0) begin
          p0 = respPresent;
          m0 = respMinCount;
        end else begin
          check("hold_write_en", memWriteEn, 1'b0);
          check("hold_present_stable", respPresent, p0);
          check("hold_min_stable", respMinCount, m0);
        end
      end
      @(posedge clk); #1;
      respReady = 1'b1;
      cmdValid  = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      done = cmdReady;
    end
    check("return_idle", done, 1'b1);
    check("resp_drained", sb.size(), 0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rstb = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdBlockAddr = '0; cmdHashes = '0;
    respReady = 1'b0;
    //          op     addr    h0     h1     h2    hold p     min
    vecs.push_back('{2'b01, 12'd5, 4'd2,  4'd7, 4'd9,  0, 1'b0, 4'd0});
    vecs.push_back('{2'b01, 12'd5, 4'd2,  4'd7, 4'd9,  0, 1'b1, 4'd1});
    vecs.push_back('{2'b00, 12'd5, 4'd2,  4'd7, 4'd9,  0, 1'b1, 4'd2});
    vecs.push_back('{2'b10, 12'd5, 4'd2,  4'd7, 4'd9,  0, 1'b1, 4'd2});
    vecs.push_back('{2'b10, 12'd6, 4'd3,  4'd4, 4'd6,  0, 1'b0, 4'd0});
    vecs.push_back('{2'b01, 12'd6, 4'd3,  4'd3, 4'd3,  4, 1'b1, 4'hF});
    vecs.push_back('{2'b01, 12'd7, 4'd8,  4'd8, 4'd8,  0, 1'b0, 4'd0});
    vecs.push_back('{2'b00, 12'd7, 4'd8,  4'd8, 4'd8,  0, 1'b1, 4'd1});
    vecs.push_back('{2'b11, 12'd7, 4'd8,  4'd1, 4'd8,  0, 1'b0, 4'd0});
    vecs.push_back('{2'b01, 12'd7, 4'd15, 4'd0, 4'd8,  0, 1'b0, 4'd0});
    vecs.push_back('{2'b00, 12'd7, 4'd15, 4'd0, 4'd8,  0, 1'b1, 4'd1});
    vecs.push_back('{2'b10, 12'd5, 4'd2,  4'd2, 4'd7,  0, 1'b1, 4'd1});
    vecs.push_back('{2'b00, 12'd5, 4'd2,  4'd7, 4'd9,  0, 1'b0, 4'd0});

    #12;
    check("rst_cmd_ready", cmdReady, 1'b1);
    check("rst_outputs", {memReadEn, memWriteEn, respValid, respPresent}, 4'b0);
    check("rst_buses", {memWriteData, memWriteAddr, respMinCount}, '0);
    @(posedge clk); #1;
    rstb = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      // Block 6: entry 3 saturated, entry 4 empty, entry 6 at one.
      if (i == 4) preload(12'd6, 64'h0000_0000_0100_F000);
      v = vecs[i];
      run_cmd(v);
    end

    // Reset during READ aborts the command: no write and no response.
    @(posedge clk); #1;
    cmdValid = 1'b1; cmdOp = 2'b01; cmdBlockAddr = 12'd9; cmdHashes = {4'd3, 4'd2, 4'd1};
    respReady = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    #2;
    rstb = 1'b0;
    #1;
    check("abort_cmd_ready", cmdReady, 1'b1);
    check("abort_outputs", {memReadEn, memWriteEn, respValid, respPresent}, 4'b0);
    check("abort_buses", {memWriteData, memWriteAddr, respMinCount}, '0);
    #10;
    sb.delete();
    writes_seen = 0;
    rstb = 1'b1;
    @(negedge clk);
    check("abort_release_ready", cmdReady, 1'b1);
    repeat (3) @(negedge clk);
    check("abort_no_write", mem[9], 64'h0);
    v = '{2'b00, 12'd9, 4'd1, 4'd2, 4'd3, 0, 1'b0, 4'd0};
    run_cmd(v);

    check("final_queue_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cbf_block_updater.md
Name: cbf_block_updater

Overview:
- Sequential read-modify-write engine sitting between the CBF command stream and the block memory.
- Accepts query/insert/delete commands carrying a block address and packed hashes.
- Reads one packed CBF block, applies a saturating increment or decrement at the hashed entries, writes the block back, and returns a membership/min-count response.
- Unpipelined: one command in flight; the write is complete before the next read, so there are no RAW hazards.

Parameters:
NUM_HASHES, 6, hash functions per command
VECTOR_WIDTH, 1024, CBF entries per block
NUM_BITS_TO_ADDRESS_VECTOR, 10, bits per hash
CBF_WIDTH, 4, bits per CBF entry
ADDR_WIDTH, 12, block memory address width

Ports:
clk  input  1  clock
rstb  input  1  asynchronous active-low reset
cmdValid  input  1  command valid
cmdReady  output  1  engine can accept a command
cmdOp  input  2  00 query, 01 insert, 10 delete, 11 treated as query
cmdBlockAddr  input  ADDR_WIDTH  block address
cmdHashes  input  NUM_BITS_TO_ADDRESS_VECTOR*NUM_HASHES  packed hashes, hash l at [(l+1)*N-1:l*N]
memReadEn  output  1  memory read strobe
memReadAddr  output  ADDR_WIDTH  read address
memReadData  input  CBF_WIDTH*VECTOR_WIDTH  block, valid exactly 1 cycle after memReadEn
memWriteEn  output  1  memory write strobe
memWriteAddr  output  ADDR_WIDTH  write address
memWriteData  output  CBF_WIDTH*VECTOR_WIDTH  updated block
respValid  output  1  response valid
respReady  input  1  response accepted
respPresent  output  1  all hashed entries nonzero (pre-update)
respMinCount  output  CBF_WIDTH  minimum hashed entry value (pre-update)

Behaviour:
- Clock and reset: single clock clk; reset rstb is asynchronous, active-low.
- Reset values: state IDLE, cmdReady=1, all other outputs 0 (including data and address buses).
- Asserting rstb low mid-operation aborts the command with no write and no response.
- FSM states: IDLE, READ, WRITE, HOLD.
- IDLE:
  - cmdReady=1.
  - memReadEn=cmdValid and memReadAddr=cmdBlockAddr, combinational in this state only.
  - On cmdValid: latch op, addr and hashes; go to READ.
- READ:
  - cmdReady=0; memReadData is valid.
  - At the clock edge, register the updated block, respPresent and respMinCount; go to WRITE.
- WRITE:
  - memWriteEn=1 for exactly this cycle, and only when op is insert or delete; memWriteAddr=latched addr.
  - respValid=1.
  - respReady=1 goes to IDLE; otherwise go to HOLD.
- HOLD: respValid=1 and response outputs stable until respReady; then IDLE. No memory activity.
- Command-to-response latency: 2 cycles after the handshake. Minimum 3 cycles per command.
- Entry m is "hit" if any hash equals m. Duplicate hashes hit an entry once, so a single ±1 applies.
- Insert: each hit entry increments by 1, saturating at all-ones.
- Delete:
  - Each hit entry decrements by 1.
  - An entry at 0 stays 0.
  - An entry at all-ones is sticky and is not decremented.
- CBF_WIDTH=1:
  - Insert sets the hit bits.
  - Delete leaves the block unchanged, but memWriteEn still pulses with unchanged data.
- Entries that are not hit are passed through bit-exact.
- Hash values at or above VECTOR_WIDTH hit nothing and read as 0 for the response.
- respPresent and respMinCount always reflect the block as read, before modification, for every op.
- cmdReady is 0 in READ, WRITE and HOLD. Commands presented then are not consumed.

Test Plan:
- Parameters VECTOR_WIDTH=16, CBF_WIDTH=4, NUM_HASHES=3, N=4, memory zeroed. Insert addr 5, hashes {2,7,9} -> read at cycle 0; write at cycle 2 with entries 2, 7, 9 = 1 and others 0; respPresent=0, respMinCount=0.
- Repeat the same insert, then query with the same hashes -> query returns respPresent=1, respMinCount=2; memWriteEn stays 0 during the query.
- Entry 3 = 0xF, entry 4 = 0x0, entry 6 = 0x1. Delete hashes {3,4,6} -> written entries 0xF, 0x0, 0x0; respMinCount=0. Insert with 0xF present -> entry stays 0xF.
- Insert hashes {8,8,8} on a zero block -> entry 8 = 1, not 3.
- Hold respReady=0 for 4 cycles after WRITE -> respValid is held with stable data; memWriteEn pulses once; cmdReady=0 until respReady is accepted.
- Drop rstb for one cycle while in READ -> all outputs 0 immediately; no memWriteEn; cmdReady=1 after release.
